// File: rtl/uart_pkg.sv
// uart_pkg: parity codes, FSM encoding and baud divisor shared by the UART TX and RX blocks
package uart_pkg;
    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} uart_state_e;

    function automatic int baud_div(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction
endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: single-clock first-word-out FIFO; writes to a full FIFO are refused even with a pop
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clockIN,
    input  logic                     nTxResetIN,
    input  logic                     i_wr,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_rd,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic             w_wr;
    logic             w_rd;

    assign o_full  = r_level == LW'(DEPTH);
    assign o_empty = r_level == '0;
    assign o_level = r_level;
    assign o_data  = r_mem[r_rd_ptr];
    assign w_wr    = i_wr && !o_full;
    assign w_rd    = i_rd && !o_empty;

    always_ff @(posedge clockIN or negedge nTxResetIN) begin
        if (!nTxResetIN) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
            r_level <= r_level + LW'(w_wr) - LW'(w_rd);
        end
    end

    always_ff @(posedge clockIN) begin
        if (w_wr) r_mem[r_wr_ptr] <= i_data;
    end
endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered UART transmitter with clock-enable baud timing and registered line output
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQUENCY = 50_000_000,
    parameter int BAUD_RATE       = 9600,
    parameter int DATA_BITS       = 8,
    parameter int PARITY          = 0,
    parameter int STOP_BITS       = 1,
    parameter int FIFO_DEPTH      = 16
) (
    input  logic                          clockIN,
    input  logic                          nTxResetIN,
    input  logic [DATA_BITS-1:0]          txDataIN,
    input  logic                          txLoadIN,
    output logic                          txReadyOUT,
    output logic                          txIdleOUT,
    output logic [$clog2(FIFO_DEPTH):0]   txLevelOUT,
    output logic                          txOverflowOUT,
    output logic                          txOUT
);
    localparam int BAUD_DIV = baud_div(CLOCK_FREQUENCY, BAUD_RATE);
    localparam int CW       = $clog2(BAUD_DIV);
    localparam int BW       = 4;

    if (BAUD_DIV < 2 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > PARITY_EVEN ||
        (STOP_BITS != 1 && STOP_BITS != 2) || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
        $error("uart_tx_fifo: illegal parameter combination");
    end

    uart_state_e          r_state, w_state_n;
    logic [CW-1:0]        r_cnt, w_cnt_n;
    logic [BW-1:0]        r_bits, w_bits_n;
    logic [DATA_BITS-1:0] r_shift, w_shift_n;
    logic                 r_par, w_par_n;
    logic                 r_tx, w_tx_n;
    logic                 r_idle;
    logic                 r_ovf;
    logic                 w_tick, w_start, w_pop, w_empty, w_full;
    logic [DATA_BITS-1:0] w_head;

    uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clockIN    (clockIN),
        .nTxResetIN (nTxResetIN),
        .i_wr       (txLoadIN),
        .i_data     (txDataIN),
        .i_rd       (w_pop),
        .o_data     (w_head),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_level    (txLevelOUT)
    );

    assign w_tick        = r_cnt == CW'(BAUD_DIV - 1);
    assign w_start       = !w_empty && (r_state == ST_IDLE || (r_state == ST_STOP && w_tick && r_bits == '0));
    assign w_pop         = w_start;
    assign txReadyOUT    = !w_full;
    assign txIdleOUT     = r_idle;
    assign txOverflowOUT = r_ovf;
    assign txOUT         = r_tx;

    always_ff @(posedge clockIN or negedge nTxResetIN) begin
        if (!nTxResetIN) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_bits  <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_tx    <= 1'b1;
            r_idle  <= 1'b1;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_bits  <= w_bits_n;
            r_shift <= w_shift_n;
            r_par   <= w_par_n;
            r_tx    <= w_tx_n;
            r_idle  <= w_state_n == ST_IDLE && w_empty && !txLoadIN;
            r_ovf   <= txLoadIN && w_full;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_state == ST_IDLE ? r_cnt : (w_tick ? '0 : r_cnt + CW'(1));
        w_bits_n  = r_bits;
        w_shift_n = r_shift;
        w_par_n   = r_par;
        w_tx_n    = r_tx;
        case (r_state)
            ST_START: if (w_tick) begin
                w_state_n = ST_DATA;
                w_tx_n    = r_shift[0];
                w_shift_n = r_shift >> 1;
                w_bits_n  = BW'(DATA_BITS - 1);
            end
            ST_DATA: if (w_tick) begin
                w_state_n = r_bits != '0 ? ST_DATA : (PARITY != PARITY_NONE ? ST_PARITY : ST_STOP);
                w_tx_n    = r_bits != '0 ? r_shift[0] : (PARITY != PARITY_NONE ? r_par : 1'b1);
                w_shift_n = r_shift >> 1;
                w_bits_n  = r_bits != '0 ? r_bits - BW'(1) : BW'(STOP_BITS - 1);
            end
            ST_PARITY: if (w_tick) begin
                w_state_n = ST_STOP;
                w_tx_n    = 1'b1;
                w_bits_n  = BW'(STOP_BITS - 1);
            end
            ST_STOP: if (w_tick) begin
                w_state_n = r_bits == '0 ? ST_IDLE : ST_STOP;
                w_bits_n  = r_bits == '0 ? r_bits : r_bits - BW'(1);
            end
            default: ;
        endcase
        // IDLE with data and a STOP ending with data share one frame launch
        if (w_start) begin
            w_state_n = ST_START;
            w_cnt_n   = '0;
            w_tx_n    = 1'b0;
            w_shift_n = w_head;
            w_par_n   = ^w_head ^ (PARITY == PARITY_ODD);
        end
    end
endmodule
